// File: rtl/latch_loader.sv
// latch_loader: FIFO-buffered feeder for a transparent latch stage.
// Words arrive over a valid/ready handshake and are buffered in a small FIFO.
// Each word is then presented on D with a fixed setup / gate-pulse / hold
// sequence on G, so the downstream latch sees a clean, glitch-free load.
//
// Handshake: a word transfers on every rising edge where IN_VALID and
// IN_READY are both high. IN_READY depends only on the registered occupancy
// and reset, never on IN_VALID. There is no same-cycle pop bypass.
module latch_loader #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [WIDTH-1:0]         IN_DATA,
    output logic [WIDTH-1:0]         D,
    output logic                     G,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [1:0]               DBG_STATE
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int MAX_SP = (SETUP > PULSE) ? SETUP : PULSE;
    localparam int MAX_C  = (MAX_SP > HOLD) ? MAX_SP : HOLD;
    // cnt only needs to reach MAX_C-1; keep at least one bit.
    localparam int CNT_W  = (MAX_C < 2) ? 1 : $clog2(MAX_C);

    localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_GATE = 2'd2,
        ST_HLD  = 2'd3
    } state_t;

    // Registered state
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                g_q, g_d;
    logic [WIDTH-1:0]    d_q, d_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];

    logic                push;
    logic                pop;
    logic                fifo_nonempty;

    assign IN_READY      = (count_q < DEPTH_C) && RSTN;
    assign push          = IN_VALID && IN_READY;
    assign fifo_nonempty = (count_q != '0);

    assign D         = d_q;
    assign G         = g_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign COUNT     = count_q;
    assign DBG_STATE = state_q;

    // Load sequencer: next state, cycle counter, gate and pop decision.
    // Pops happen only from IDLE or at HLD exit, both with G low, so D never
    // moves while the latch is transparent.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                g_d = 1'b0;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                g_d = 1'b0;
                if (cnt_q == SETUP_END) begin
                    g_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GATE: begin
                g_d = 1'b1;
                if (cnt_q == PULSE_END) begin
                    g_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_HLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HLD: begin
                g_d = 1'b0;
                if (cnt_q == HOLD_END) begin
                    cnt_d = '0;
                    // Decision uses registered occupancy: a word pushed on
                    // this very edge is picked up from IDLE one edge later.
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        state_d = ST_SET;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                g_d     = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer, occupancy and output data next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        d_d      = d_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            d_d      = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents are don't-care after reset since pointers clear.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= IN_DATA;
        end
    end

    // State registers; async reset drops G immediately, even mid-gate.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            g_q      <= 1'b0;
            d_q      <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            g_q      <= g_d;
            d_q      <= d_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_latch_loader.sv
// Directed testbench for latch_loader with default parameters.
module tb_latch_loader;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [3:0] IN_DATA = 4'h0;
  logic [3:0] D;
  logic       G;
  logic       BUSY;
  logic [2:0] COUNT;
  logic [1:0] DBG_STATE;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  bit g_prev = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] latch_q;

  // clock / reset block
  always #5 CLK = ~CLK;

  latch_loader #(
    .WIDTH(4), .DEPTH(4), .SETUP(1), .PULSE(2), .HOLD(1)
  ) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .IN_DATA(IN_DATA),
    .D(D),
    .G(G),
    .BUSY(BUSY),
    .COUNT(COUNT),
    .DBG_STATE(DBG_STATE)
  );

  // downstream transparent latch model
  always_latch begin
    if (G) latch_q = D;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one clock edge; records accepted words and checks D order at each G rise
  task automatic tick(output bit acc);
    acc = (IN_VALID === 1'b1) && (IN_READY === 1'b1);
    if (acc) exp_q.push_back(IN_DATA);
    @(posedge CLK);
    #1;
    if ((G === 1'b1) && !g_prev) begin
      pulses++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL g_pulse_unexpected: observed=pulse expected=no_pulse");
      end
      if (exp_q.size() != 0) chk("d_order_at_gate", D, exp_q.pop_front());
    end
    g_prev = (G === 1'b1);
  endtask

  // expected tables for back-to-back test, edges 0..13
  logic [3:0] t3_d   [14] = '{4'hA,4'h1,4'h1,4'h1,4'h1,4'h2,4'h2,4'h2,4'h2,4'h3,4'h3,4'h3,4'h3,4'h3};
  logic       t3_g   [14] = '{0,0,1,1,0,0,1,1,0,0,1,1,0,0};
  logic [2:0] t3_cnt [14] = '{1,1,2,2,2,1,1,1,1,0,0,0,0,0};
  logic       t3_busy[14] = '{0,1,1,1,1,1,1,1,1,1,1,1,1,0};

  initial begin
    bit acc;
    int idx;
    int p0;
    bit found;

    // 1. reset values
    #2 RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_d", D, 4'h0);
    chk("rst_g", G, 1'b0);
    chk("rst_count", COUNT, 3'd0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_in_ready", IN_READY, 1'b0);
    RSTN = 1'b1;
    tick(acc);
    chk("rel_in_ready", IN_READY, 1'b1);
    chk("rel_busy", BUSY, 1'b0);

    // 2. single word
    IN_VALID = 1'b1; IN_DATA = 4'hA;
    tick(acc);                       // edge 0
    IN_VALID = 1'b0;
    chk("s_e0_count", COUNT, 3'd1);
    chk("s_e0_g", G, 1'b0);
    tick(acc);                       // edge 1
    chk("s_e1_d", D, 4'hA);
    chk("s_e1_g", G, 1'b0);
    chk("s_e1_busy", BUSY, 1'b1);
    chk("s_e1_count", COUNT, 3'd0);
    tick(acc);                       // edge 2
    chk("s_e2_g", G, 1'b1);
    tick(acc);                       // edge 3
    chk("s_e3_g", G, 1'b1);
    tick(acc);                       // edge 4
    chk("s_e4_g", G, 1'b0);
    chk("s_e4_busy", BUSY, 1'b1);
    chk("s_e4_d", D, 4'hA);
    tick(acc);                       // edge 5
    chk("s_e5_busy", BUSY, 1'b0);
    chk("s_latch_q", latch_q, 4'hA);

    // 3. back-to-back
    for (int e = 0; e < 14; e++) begin
      IN_VALID = (e < 3);
      IN_DATA = 4'(e + 1);
      tick(acc);
      chk($sformatf("b2b_e%0d_d", e), D, t3_d[e]);
      chk($sformatf("b2b_e%0d_g", e), G, t3_g[e]);
      chk($sformatf("b2b_e%0d_count", e), COUNT, t3_cnt[e]);
      chk($sformatf("b2b_e%0d_busy", e), BUSY, t3_busy[e]);
    end
    IN_VALID = 1'b0;

    // 4. full FIFO with continuous valid
    idx = 0;
    p0 = pulses;
    for (int e = 0; e < 30; e++) begin
      IN_VALID = (idx < 6);
      IN_DATA = 4'(idx);
      tick(acc);
      if (acc) idx++;
      if (e == 4) begin
        chk("full_e4_count", COUNT, 3'd4);
        chk("full_e4_ready", IN_READY, 1'b0);
      end
      if (e == 5) begin
        chk("full_e5_ready", IN_READY, 1'b1);
        chk("full_e5_count", COUNT, 3'd3);
        chk("full_e5_d", D, 4'h1);
      end
    end
    IN_VALID = 1'b0;
    chk("full_accepted", idx, 6);
    chk("full_pulses", pulses - p0, 6);
    chk("full_drained_count", COUNT, 3'd0);
    chk("full_drained_busy", BUSY, 1'b0);
    chk("full_last_d", D, 4'h5);

    // 5. pointer wrap with random valid gaps
    idx = 0;
    p0 = pulses;
    for (int e = 0; e < 400; e++) begin
      if (idx == 10 && BUSY === 1'b0 && COUNT === 3'd0) break;
      IN_VALID = (idx < 10) && ($urandom_range(0, 1) == 1);
      IN_DATA = 4'(idx);
      tick(acc);
      if (acc) idx++;
    end
    IN_VALID = 1'b0;
    chk("wrap_accepted", idx, 10);
    chk("wrap_pulses", pulses - p0, 10);
    chk("wrap_queue_left", exp_q.size(), 0);
    chk("wrap_last_d", D, 4'h9);

    // 6. reset mid-gate
    for (int e = 0; e < 3; e++) begin
      IN_VALID = 1'b1;
      IN_DATA = 4'(4'hB + e);
      tick(acc);
    end
    IN_VALID = 1'b0;
    found = 1'b0;
    for (int e = 0; e < 20; e++) begin
      if (G === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick(acc);
    end
    chk("mid_gate_reached", found, 1'b1);
    chk("mid_count_before", COUNT, 3'd2);
    #2 RSTN = 1'b0;
    #1;
    chk("mid_rst_g", G, 1'b0);
    chk("mid_rst_count", COUNT, 3'd0);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_ready", IN_READY, 1'b0);
    exp_q.delete();
    g_prev = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    tick(acc);
    chk("mid_rel_count", COUNT, 3'd0);
    chk("mid_rel_busy", BUSY, 1'b0);
    p0 = pulses;
    IN_VALID = 1'b1; IN_DATA = 4'h7;
    tick(acc);
    IN_VALID = 1'b0;
    repeat (8) tick(acc);
    chk("mid_pulses", pulses - p0, 1);
    chk("mid_d", D, 4'h7);
    chk("mid_latch_q", latch_q, 4'h7);
    chk("mid_final_busy", BUSY, 1'b0);
    chk("mid_final_count", COUNT, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/latch_loader.md
# latch_loader

Upstream feeder for the transparent `LATCH` stage. It accepts data words over a valid/ready handshake and buffers them in a small FIFO. It then drives the latch's data and gate inputs with a fixed, parameterised setup / gate-pulse / hold sequence per word. Its `D` and `G` outputs connect directly to the latch's `D` and `G`, replacing free-running clock gating with controlled, glitch-free loads.

## Interface
- `WIDTH`, 4: data width; matches the latch `WIDTH`.
- `DEPTH`, 4: FIFO depth; must be a power of 2 and ≥2.
- `SETUP`, 1: cycles `D` is stable with `G` low before the gate opens; ≥1.
- `PULSE`, 2: cycles `G` is high; ≥1.
- `HOLD`, 1: cycles `D` is stable with `G` low after the gate closes; ≥1.

Ports (CW = $clog2(DEPTH)+1):
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RSTN`  in  1  asynchronous, active-low reset.
- `IN_VALID`  in  1  upstream word valid.
- `IN_READY`  out  1  FIFO can accept; `(COUNT < DEPTH) && RSTN`.
- `IN_DATA`  in  WIDTH  upstream word.
- `D`  out  WIDTH  registered data to the latch `D`.
- `G`  out  1  registered gate to the latch `G`.
- `BUSY`  out  1  high when the FSM is not in IDLE.
- `COUNT`  out  CW  current FIFO occupancy.

## Operation
- **FIFO push:** a word is pushed on any edge where `IN_VALID && IN_READY`. `IN_READY` depends only on registered `COUNT`, with no same-cycle pop bypass. Push and pop on the same edge leave `COUNT` unchanged.
- **FIFO storage:** read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Output order equals input order.
- **FSM states:** IDLE, SET, GATE, HLD. A cycle counter `cnt` counts cycles within each state.
  - **IDLE:** `G`=0. If `COUNT`≠0: pop the head into `D`, set `cnt`=0, go to SET. Otherwise stay; `D` retains its last value.
  - **SET:** `G`=0. When `cnt`==SETUP-1, set `G`←1, `cnt`←0, go to GATE. Otherwise increment `cnt`.
  - **GATE:** `G`=1. When `cnt`==PULSE-1, set `G`←0, `cnt`←0, go to HLD. Otherwise increment `cnt`.
  - **HLD:** `G`=0. When `cnt`==HOLD-1:
    - if `COUNT`≠0, pop the next word into `D` and go to SET (back-to-back, no IDLE cycle);
    - otherwise go to IDLE.
- **Output stability:** `D` changes only on pop edges, and a pop edge never coincides with `G`=1. `G` is a flop output, never decoded combinationally.
- **Reset:** `RSTN` low asynchronously clears everything:
  - `D`=0, `G`=0, `COUNT`=0, both pointers 0, state IDLE, `cnt`=0;
  - therefore `BUSY`=0 and `IN_READY`=0.
  - FIFO contents are discarded.
- **Reset mid-operation:** asserting `RSTN` during GATE drops `G` immediately, without waiting for an edge. After release, the block is idle and empty.
- **Reset release:** `IN_READY`=1 from the first edge after release.

## Timing
- **Single-word latency:** word accepted at edge k into an empty FIFO with FSM in IDLE.
  - Pop at edge k+1; `D` valid after k+1.
  - `G` rises after edge k+1+SETUP and falls after edge k+1+SETUP+PULSE.
  - FSM is back in IDLE (`BUSY`=0) after edge k+1+SETUP+PULSE+HOLD.
- **Throughput:** one word per SETUP+PULSE+HOLD cycles when the FIFO stays non-empty.
- **Full:** `IN_READY`=0 while `COUNT`==DEPTH. An upstream word held with `IN_VALID` is accepted on the first edge after `COUNT` drops.
- **Empty:** the FSM never pops when `COUNT`==0.
- **Simultaneous events:** on an HLD-exit edge, a word pushed on that same edge into an empty FIFO is not popped. The FSM goes to IDLE and pops it one edge later.

## Test plan
1. **Reset values:** hold `RSTN`=0 for 3 cycles → `D`=0, `G`=0, `COUNT`=0, `BUSY`=0, `IN_READY`=0. Release → `IN_READY`=1 after the next edge.
2. **Single word** (defaults): push 4'hA at edge 0 → `D`=4'hA after edge 1; `G`=1 after edges 2–3, 0 after edge 4; `BUSY`=0 after edge 5. The latch `Q` shows 4'hA.
3. **Back-to-back:** push 4'h1, 4'h2, 4'h3 on consecutive edges 0–2 → pops at edges 1, 5, 9. `G` goes high for 2 cycles after edges 2, 6, 10. No IDLE cycle between words.
4. **Full:** assert `IN_VALID` continuously with data 0..5 from edge 0 → `COUNT`=4 and `IN_READY`=0 after edge 4. `IN_READY`=1 again after edge 5 (pop of word 1). Words 0..5 appear on `D` in order.
5. **Pointer wrap:** stream 10 words 4'h0..4'h9 with random `IN_VALID` gaps → `D` sequence is 0..9 exactly once each. `G` pulse count is 10.
6. **Reset mid-gate:** with 3 words queued, drop `RSTN` while `G`=1 → `G`=0 before the next edge and `COUNT`=0. After release and a push of 4'h7, only 4'h7 is loaded.
